// File: rtl/lc3b_types.sv
// Shared LC-3b fetch types: BTB way/set/tag widths, PLRU state,
// BTB controller states, PC field positions and PLRU helper functions.
package lc3b_types;

    typedef logic [1:0] lc3b_pc_ways;
    typedef logic [3:0] lc3b_set;
    typedef logic [9:0] lc3b_pc_tag;
    typedef logic [2:0] lc3b_plru;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        ALLOC
    } btb_state_t;

    localparam int BTB_SET_LSB = 2;
    localparam int BTB_TAG_LSB = 6;

    // b0 points at the colder half, b1/b2 at the colder way in each half.
    function automatic lc3b_plru plru_touch(lc3b_plru p, lc3b_pc_ways w);
        lc3b_plru n;
        n = p;
        n[0] = (w < 2'd2);
        if (w < 2'd2) n[1] = (w == 2'd0);
        else          n[2] = (w == 2'd2);
        return n;
    endfunction

    function automatic lc3b_pc_ways plru_victim(lc3b_plru p);
        if (!p[0]) return p[1] ? 2'd1 : 2'd0;
        return p[2] ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set tree PLRU array (16 x 3 bits) with combinational victim read.
// Ports: clk, rst_n (sync, active-low), rd_set -> victim, touch ports A/B (A wins).
module btb_plru
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rd_set,
    output logic [1:0] victim,
    input  logic       a_en,
    input  logic [3:0] a_set,
    input  logic [1:0] a_way,
    input  logic       b_en,
    input  logic [3:0] b_set,
    input  logic [1:0] b_way
);

    lc3b_plru bits [NUM_SETS];

    assign victim = plru_victim(bits[rd_set]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) bits[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (a_en && a_set == lc3b_set'(s))
                    bits[s] <= plru_touch(bits[s], a_way);
                else if (b_en && b_set == lc3b_set'(s))
                    bits[s] <= plru_touch(bits[s], b_way);
            end
        end
    end

endmodule

// File: rtl/btb_way_ctrl.sv
// BTB tag-compare / valid / PLRU replacement controller for a 4-way x 16-set tag store.
// Ports: fetch_pc/fetch_en -> fetch_hit/fetch_way; upd_valid/upd_pc/upd_ready update
// handshake; tag_in0..3 <- store read at read_set; tag_load/tag_wdata/load_set/load_way
// drive the store write. Optional BTB_STATS_EN adds stat_hits/stat_lookups/stat_allocs.
module btb_way_ctrl
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fetch_pc,
    input  logic        fetch_en,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    output logic        upd_ready,
    input  logic [9:0]  tag_in0,
    input  logic [9:0]  tag_in1,
    input  logic [9:0]  tag_in2,
    input  logic [9:0]  tag_in3,
    output logic [3:0]  read_set,
    output logic        tag_load,
    output logic [9:0]  tag_wdata,
    output logic [3:0]  load_set,
    output logic [1:0]  load_way,
    output logic        fetch_hit,
    output logic [1:0]  fetch_way
`ifdef BTB_STATS_EN
    ,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_lookups,
    output logic [15:0] stat_allocs
`endif
);

    btb_state_t state, state_nx;

    logic [NUM_WAYS-1:0] valid [NUM_SETS];

    lc3b_set     cap_set;
    lc3b_pc_tag  cap_tag;
    lc3b_set     fetch_set;
    lc3b_pc_tag  fetch_tag;
    lc3b_pc_tag  cur_tag;
    lc3b_pc_tag  tag_w [4];
    logic [3:0]  hit;
    lc3b_pc_ways hit_way;
    lc3b_pc_ways inv_way;
    lc3b_pc_ways plru_vic;
    lc3b_pc_ways victim;
    logic        all_valid;
    logic        lookup_on;
    logic        a_en;
    lc3b_pc_ways a_way;
    logic        unused_pc_lsb;

    assign unused_pc_lsb = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign fetch_set = fetch_pc[BTB_SET_LSB +: 4];
    assign fetch_tag = fetch_pc[BTB_TAG_LSB +: 10];

    assign tag_w[0] = tag_in0;
    assign tag_w[1] = tag_in1;
    assign tag_w[2] = tag_in2;
    assign tag_w[3] = tag_in3;

    // The read port serves the probe only while in PROBE; otherwise fetch owns it.
    assign read_set = (state == PROBE) ? cap_set : fetch_set;
    assign cur_tag  = (state == PROBE) ? cap_tag : fetch_tag;

    always_comb begin
        hit = '0;
        for (int w = 0; w < 4; w++)
            hit[w] = valid[read_set][w] && (tag_w[w] == cur_tag);
    end

    always_comb begin
        hit_way = 2'd0;
        for (int w = 3; w >= 0; w--)
            if (hit[w]) hit_way = lc3b_pc_ways'(w);
    end

    always_comb begin
        inv_way = 2'd0;
        for (int w = 3; w >= 0; w--)
            if (!valid[cap_set][w]) inv_way = lc3b_pc_ways'(w);
    end

    assign all_valid = &valid[cap_set];
    assign victim    = all_valid ? plru_vic : inv_way;

    assign upd_ready = (state == IDLE);
    assign lookup_on = fetch_en && (state != PROBE);
    assign fetch_hit = lookup_on && (|hit);
    assign fetch_way = fetch_hit ? hit_way : 2'd0;

    always_comb begin
        state_nx = state;
        a_en     = 1'b0;
        a_way    = hit_way;
        unique case (state)
            IDLE: begin
                if (upd_valid) state_nx = PROBE;
            end
            PROBE: begin
                if (|hit) begin
                    a_en     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = ALLOC;
                end
            end
            ALLOC: begin
                a_en     = 1'b1;
                a_way    = load_way;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    btb_plru #(
        .NUM_SETS(NUM_SETS)
    ) u_plru (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_set(cap_set),
        .victim(plru_vic),
        .a_en  (a_en),
        .a_set (cap_set),
        .a_way (a_way),
        .b_en  (fetch_hit),
        .b_set (fetch_set),
        .b_way (hit_way)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_set   <= '0;
            cap_tag   <= '0;
            tag_load  <= 1'b0;
            tag_wdata <= '0;
            load_set  <= '0;
            load_way  <= '0;
            for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
        end else begin
            state     <= state_nx;
            tag_load  <= 1'b0;
            tag_wdata <= '0;
            load_set  <= '0;
            load_way  <= '0;
            if (state == IDLE && upd_valid) begin
                cap_set <= upd_pc[BTB_SET_LSB +: 4];
                cap_tag <= upd_pc[BTB_TAG_LSB +: 10];
            end
            // Write strobe and payload are held for exactly the ALLOC cycle.
            if (state == PROBE && !(|hit)) begin
                tag_load  <= 1'b1;
                tag_wdata <= cap_tag;
                load_set  <= cap_set;
                load_way  <= victim;
            end
            if (state == ALLOC) valid[cap_set][load_way] <= 1'b1;
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hits    <= '0;
            stat_lookups <= '0;
            stat_allocs  <= '0;
        end else begin
            if (fetch_hit && stat_hits != 16'hFFFF)
                stat_hits <= stat_hits + 16'd1;
            if (lookup_on && stat_lookups != 16'hFFFF)
                stat_lookups <= stat_lookups + 16'd1;
            if (state == ALLOC && stat_allocs != 16'hFFFF)
                stat_allocs <= stat_allocs + 16'd1;
        end
    end
`endif

endmodule
